// File: rtl/wfg_stim_mem_reg_pkg.sv
// Shared offsets, field widths, reset values and channel register type for the stimulus-memory register block.
package wfg_stim_mem_reg_pkg;

    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_START = 4'h4;
    localparam logic [3:0] OFF_END   = 4'h8;
    localparam logic [3:0] OFF_INC   = 4'hC;
    localparam logic [7:0] ADR_DONE  = 8'h80;

    localparam int START_W = 16;
    localparam int END_W   = 16;
    localparam int INC_W   = 8;

    localparam logic               EN_RST      = 1'b0;
    localparam logic [START_W-1:0] START_RST   = '0;
    localparam logic [END_W-1:0]   END_RST     = '0;
    localparam logic [INC_W-1:0]   INC_RST_DEF = 8'h01;

    typedef struct packed {
        logic               en;
        logic [START_W-1:0] start_val;
        logic [END_W-1:0]   end_val;
        logic [INC_W-1:0]   inc_val;
    } chan_regs_t;

endpackage

// File: rtl/wfg_stim_mem_reg_chan.sv
// One channel's CTRL/START/END/INC registers with byte-lane writes and a combinational read mux.
// Write commits on the edge where wr is high; no backpressure of its own.
module wfg_stim_mem_reg_chan
    import wfg_stim_mem_reg_pkg::*;
#(
    parameter logic [INC_W-1:0] INC_RST = INC_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [3:0]  off,
    input  logic [3:0]  sel,
    input  logic [31:0] wdat,
    output chan_regs_t  regs,
    output logic [31:0] rdat
);

    // Upper lanes/bits never reach a field narrower than 17 bits.
    logic unused_bits;
    assign unused_bits = ^{wdat[31:16], sel[3:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            regs.en        <= EN_RST;
            regs.start_val <= START_RST;
            regs.end_val   <= END_RST;
            regs.inc_val   <= INC_RST;
        end else if (wr) begin
            case (off)
                OFF_CTRL: begin
                    if (sel[0]) regs.en <= wdat[0];
                end
                OFF_START: begin
                    if (sel[0]) regs.start_val[7:0]  <= wdat[7:0];
                    if (sel[1]) regs.start_val[15:8] <= wdat[15:8];
                end
                OFF_END: begin
                    if (sel[0]) regs.end_val[7:0]  <= wdat[7:0];
                    if (sel[1]) regs.end_val[15:8] <= wdat[15:8];
                end
                OFF_INC: begin
                    if (sel[0]) regs.inc_val <= wdat[7:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdat = '0;
        case (off)
            OFF_CTRL:  rdat = {31'b0, regs.en};
            OFF_START: rdat = 32'(regs.start_val);
            OFF_END:   rdat = 32'(regs.end_val);
            OFF_INC:   rdat = 32'(regs.inc_val);
            default:   rdat = '0;
        endcase
    end

endmodule

// File: rtl/wfg_stim_mem_multi_reg.sv
// Wishbone register block for NCH stimulus channels plus sticky W1C DONE; optional wbs_err_o under WFG_STIM_MEM_REG_ERR_EN.
// One-cycle registered ack/read data; a held strobe is served every second cycle.
module wfg_stim_mem_multi_reg
    import wfg_stim_mem_reg_pkg::*;
#(
    parameter int         NCH     = 4,
    parameter int         BUSW    = 32,
    parameter logic [7:0] INC_RST = INC_RST_DEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [BUSW/8-1:0]    wbs_sel_i,
    input  logic [BUSW-1:0]      wbs_dat_i,
    input  logic [BUSW-1:0]      wbs_adr_i,
    output logic                 wbs_ack_o,
`ifdef WFG_STIM_MEM_REG_ERR_EN
    output logic                 wbs_err_o,
`endif
    output logic [BUSW-1:0]      wbs_dat_o,
    input  logic [NCH-1:0]       done_i,
    output logic [NCH-1:0]       ctrl_en_q_o,
    output logic [16*NCH-1:0]    start_val_q_o,
    output logic [16*NCH-1:0]    end_val_q_o,
    output logic [8*NCH-1:0]     inc_val_q_o
);

    logic            req;
    logic            wr;
    logic            rd;
    logic            ch_hit;
    logic            done_hit;
    logic            mapped;
    logic [NCH-1:0]  done_q;
    logic [NCH-1:0]  done_clr;
    logic [BUSW-1:0] rd_mux;
    logic [BUSW-1:0] ch_rdat [NCH];
    chan_regs_t      ch_regs [NCH];

    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    // The in-flight response blocks a new request, so a held strobe cannot commit twice.
`ifdef WFG_STIM_MEM_REG_ERR_EN
    assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & ~wbs_err_o;
`else
    assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
`endif
    assign wr  = req & wbs_we_i;
    assign rd  = req & ~wbs_we_i;

    assign ch_hit   = (wbs_adr_i[BUSW-1:7] == '0) && (int'(wbs_adr_i[6:4]) < NCH);
    assign done_hit = (wbs_adr_i[BUSW-1:8] == '0) && (wbs_adr_i[7:2] == ADR_DONE[7:2]);
    assign mapped   = ch_hit | done_hit;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wfg_stim_mem_reg_chan #(
            .INC_RST (INC_RST)
        ) u_chan (
            .clk  (wb_clk_i),
            .rst  (wb_rst_i),
            .wr   (wr && ch_hit && (wbs_adr_i[6:4] == 3'(c))),
            .off  ({wbs_adr_i[3:2], 2'b00}),
            .sel  (wbs_sel_i),
            .wdat (wbs_dat_i),
            .regs (ch_regs[c]),
            .rdat (ch_rdat[c])
        );

        assign ctrl_en_q_o[c]            = ch_regs[c].en;
        assign start_val_q_o[16*c +: 16] = ch_regs[c].start_val;
        assign end_val_q_o[16*c +: 16]   = ch_regs[c].end_val;
        assign inc_val_q_o[8*c +: 8]     = ch_regs[c].inc_val;
    end

    always_comb begin
        rd_mux = '0;
        if (done_hit) begin
            rd_mux[NCH-1:0] = done_q;
        end else if (ch_hit) begin
            for (int c = 0; c < NCH; c++) begin
                if (wbs_adr_i[6:4] == 3'(c)) rd_mux = ch_rdat[c];
            end
        end
    end

    assign done_clr = (wr && done_hit && wbs_sel_i[0]) ? wbs_dat_i[NCH-1:0] : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            done_q    <= '0;
        end else begin
`ifdef WFG_STIM_MEM_REG_ERR_EN
            wbs_ack_o <= req & mapped;
`else
            wbs_ack_o <= req;
`endif
            if (rd) wbs_dat_o <= rd_mux;
            // OR-ing the pulse after the clear lets a coincident set win.
            done_q <= (done_q & ~done_clr) | done_i;
        end
    end

`ifdef WFG_STIM_MEM_REG_ERR_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) wbs_err_o <= 1'b0;
        else          wbs_err_o <= req & ~mapped;
    end
`else
    logic unused_mapped;
    assign unused_mapped = mapped;
`endif

endmodule

// File: tb/tb_wfg_stim_mem_multi_reg.sv
// Scoreboard bench for wfg_stim_mem_multi_reg with NCH=4: register model, read queue, ack timing checks.
module tb_wfg_stim_mem_multi_reg;

    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stb = 1'b0;
    logic              cyc = 1'b0;
    logic              we  = 1'b0;
    logic [3:0]        sel = '0;
    logic [31:0]       dat = '0;
    logic [31:0]       adr = '0;
    logic              ack;
    logic              err;
    logic [31:0]       dat_o;
    logic [NCH-1:0]    done = '0;
    logic [NCH-1:0]    ctrl_en;
    logic [16*NCH-1:0] start_val;
    logic [16*NCH-1:0] end_val;
    logic [8*NCH-1:0]  inc_val;

    wfg_stim_mem_multi_reg #(.NCH(NCH), .BUSW(32), .INC_RST(8'h01)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (dat),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (ack),
`ifdef WFG_STIM_MEM_REG_ERR_EN
        .wbs_err_o     (err),
`endif
        .wbs_dat_o     (dat_o),
        .done_i        (done),
        .ctrl_en_q_o   (ctrl_en),
        .start_val_q_o (start_val),
        .end_val_q_o   (end_val),
        .inc_val_q_o   (inc_val)
    );

`ifndef WFG_STIM_MEM_REG_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference register model
    logic [31:0]    m_reg [NCH][4];
    logic [NCH-1:0] m_done;
    logic [31:0]    exp_q [$];
    logic           last_we = 1'b0;

    function automatic logic [31:0] fmask(input int r);
        case (r)
            0:       return 32'h1;
            1, 2:    return 32'hFFFF;
            default: return 32'hFF;
        endcase
    endfunction

    function automatic bit m_is_done(input logic [31:0] a);
        return a[31:2] == 30'h20;
    endfunction

    function automatic bit m_is_ch(input logic [31:0] a);
        return (a[31:8] == 24'h0) && (int'(a[7:4]) < NCH);
    endfunction

    task automatic m_reset();
        m_done = '0;
        for (int c = 0; c < NCH; c++) begin
            m_reg[c][0] = 32'h0;
            m_reg[c][1] = 32'h0;
            m_reg[c][2] = 32'h0;
            m_reg[c][3] = 32'h1;
        end
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int ch;
        int r;
        if (m_is_done(a)) begin
            if (s[0]) m_done = m_done & ~d[NCH-1:0];
        end else if (m_is_ch(a)) begin
            ch = int'(a[7:4]);
            r  = int'(a[3:2]);
            for (int i = 0; i < 4; i++)
                if (s[i]) m_reg[ch][r][8*i +: 8] = d[8*i +: 8];
            m_reg[ch][r] = m_reg[ch][r] & fmask(r);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (m_is_done(a)) return 32'(m_done);
        if (m_is_ch(a))   return m_reg[int'(a[7:4])][int'(a[3:2])];
        return 32'h0;
    endfunction

    task automatic check_outs();
        logic [NCH-1:0]    e_en;
        logic [16*NCH-1:0] e_st;
        logic [16*NCH-1:0] e_end;
        logic [8*NCH-1:0]  e_inc;
        for (int c = 0; c < NCH; c++) begin
            e_en[c]          = m_reg[c][0][0];
            e_st[16*c +: 16] = m_reg[c][1][15:0];
            e_end[16*c +: 16] = m_reg[c][2][15:0];
            e_inc[8*c +: 8]  = m_reg[c][3][7:0];
        end
        check("ctrl_en", 64'(ctrl_en), 64'(e_en));
        check("start_val", 64'(start_val), 64'(e_st));
        check("end_val", 64'(end_val), 64'(e_end));
        check("inc_val", 64'(inc_val), 64'(e_inc));
    endtask

    // Read scoreboard: every response to a read pops one expected word.
    always @(negedge clk) begin
        if ((ack || err) && !last_we) begin
            check("rd_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("rd_data", 64'(dat_o), 64'(exp_q.pop_front()));
        end
    end

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [NCH-1:0] pulse);
        logic e_ack;
        logic e_err;
        e_ack = 1'b1;
        e_err = 1'b0;
`ifdef WFG_STIM_MEM_REG_ERR_EN
        if (!(m_is_ch(a) || m_is_done(a))) begin
            e_ack = 1'b0;
            e_err = 1'b1;
        end
`endif
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s; done = pulse;
        last_we = w;
        if (!w) exp_q.push_back(m_read(a));
        if (w && e_ack) m_write(a, d, s);
        m_done = m_done | pulse;
        @(negedge clk);
        check("ack_lat", 64'(ack), 64'(e_ack));
        check("err_lat", 64'(err), 64'(e_err));
        stb = 1'b0; cyc = 1'b0; we = 1'b0; done = '0;
        @(negedge clk);
        check("ack_once", 64'(ack | err), 64'd0);
        if (w) check_outs();
    endtask

    task automatic pulse_done(input logic [NCH-1:0] p);
        @(negedge clk);
        done = p;
        m_done = m_done | p;
        @(negedge clk);
        done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_dat;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check_outs();

        // Reset readback of every register
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++)
                xfer(1'b0, 32'(16*c + 4*r), 32'h0, 4'hF, '0);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);

        // Full-word write and readback, then dat_o hold across a write
        xfer(1'b1, 32'h24, 32'h0000_1234, 4'hF, '0);
        check("start_ch2", 64'(start_val[47:32]), 64'h1234);
        xfer(1'b0, 32'h24, 32'h0, 4'hF, '0);
        xfer(1'b1, 32'h28, 32'hFFFF_9876, 4'hF, '0);
        check("dat_hold", 64'(dat_o), 64'h1234);

        // Byte-lane write
        xfer(1'b1, 32'h18, 32'h0000_5555, 4'hF, '0);
        xfer(1'b1, 32'h18, 32'h0000_ABCD, 4'b0001, '0);
        check("end_ch1", 64'(end_val[31:16]), 64'h55CD);
        xfer(1'b1, 32'h34, 32'h00AA_BB00, 4'b0010, '0);
        xfer(1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0001, '0);
        xfer(1'b0, 32'h34, 32'h0, 4'hF, '0);
        xfer(1'b0, 32'h30, 32'h0, 4'hF, '0);

        // Held strobe: ack every other cycle, one commit per ack
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h0C; sel = 4'hF; dat = 32'h10;
        last_we = 1'b1;
        check("held_ack0", 64'(ack), 64'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("held_ack", 64'(ack), 64'(k % 2));
            check("held_inc", 64'(inc_val[7:0]), (k == 3) ? 64'h12 : 64'h10);
            dat = 32'h10 + 32'(k);
        end
        held_dat = 32'h12;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        m_write(32'h0C, held_dat, 4'hF);
        @(negedge clk);
        check("held_ack_end", 64'(ack), 64'd0);
        check_outs();

        // Sticky DONE with W1C; coincident set wins
        pulse_done(4'b0100);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);
        xfer(1'b1, 32'h80, 32'h4, 4'b0001, 4'b0100);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);
        pulse_done(4'b0001);
        xfer(1'b1, 32'h80, 32'h0, 4'hF, '0);
        xfer(1'b1, 32'h80, 32'h5, 4'b1110, '0);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);
        xfer(1'b1, 32'h80, 32'h4, 4'b0001, '0);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);
        xfer(1'b1, 32'h80, 32'h1, 4'b0001, '0);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);

        // Unmapped: channel slot 4, high address bits, holes past DONE
        xfer(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, '0);
        xfer(1'b0, 32'h40, 32'h0, 4'hF, '0);
        xfer(1'b1, 32'h0001_0004, 32'h0000_BEEF, 4'hF, '0);
        xfer(1'b0, 32'h0001_0004, 32'h0, 4'hF, '0);
        xfer(1'b0, 32'h84, 32'h0, 4'hF, '0);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, '0);

        // Reset asserted together with a write request
        xfer(1'b1, 32'h00, 32'h1, 4'hF, '0);
        @(negedge clk);
        rst = 1'b1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h04; dat = 32'h0000_BEEF; sel = 4'hF;
        last_we = 1'b1;
        m_reset();
        @(negedge clk);
        check("rst_mid_ack", 64'(ack), 64'd0);
        check("rst_mid_start", 64'(start_val[15:0]), 64'h0);
        check_outs();
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        xfer(1'b0, 32'h04, 32'h0, 4'hF, '0);
        xfer(1'b0, 32'h0C, 32'h0, 4'hF, '0);
        xfer(1'b0, 32'h80, 32'h0, 4'hF, '0);

        repeat (2) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
